// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: the state type and the
// PC value that stops the core.
package codes;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC1  = 2'd1,
    EXEC2  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [31:0] HALT_ADDR = 32'h0000_0000;

  localparam int CNT_WIDTH = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear has priority.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Three-phase instruction sequencer (FETCH/EXEC1/EXEC2) with memory stalls,
// sticky halt on a zero next-PC, and saturating performance counters.
module cpu_sequencer
  import codes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest_i,
  input  logic        ram_read_en_i,
  input  logic        ram_write_en_i,
  input  logic [31:0] pc_next_i,
  output state_t      state_o,
  output logic        stall_o,
  output logic        active_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] instr_count_o,
  output logic [31:0] stall_count_o
);

  state_t state_q;
  state_t state_d;
  logic   active_q;
  logic   mem_req;
  logic   retire;

  always_comb begin
    state_d = state_q;
    mem_req = ram_read_en_i | ram_write_en_i;
    stall_o = mem_req & waitrequest_i & (state_q != HALTED);
    retire  = (state_q == EXEC2) & ~stall_o;
    if (!stall_o) begin
      unique case (state_q)
        FETCH:   state_d = EXEC1;
        EXEC1:   state_d = EXEC2;
        EXEC2:   state_d = (pc_next_i == HALT_ADDR) ? HALTED : FETCH;
        default: state_d = HALTED;
      endcase
    end
  end

  // active is registered alongside the state so it drops on HALTED entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      active_q <= (state_d != HALTED);
    end
  end

  assign state_o  = state_q;
  assign active_o = active_q;

  // Counter slots: 0 = active cycles, 1 = retired instructions, 2 = stalls.
  logic [2:0]           cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_val [3];

  assign cnt_inc[0] = active_q;
  assign cnt_inc[1] = retire;
  assign cnt_inc[2] = stall_o;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(
        .WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk     (clk),
        .clear   (reset),
        .inc_i   (cnt_inc[gi]),
        .count_o (cnt_val[gi])
      );
    end
  endgenerate

  assign cycle_count_o = cnt_val[0];
  assign instr_count_o = cnt_val[1];
  assign stall_count_o = cnt_val[2];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized and directed checks of cpu_sequencer against a phase/counter
// model, plus a narrow sat_counter to exercise saturation quickly.
module tb_cpu_sequencer;
  import codes::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest_i = 1'b0;
  logic        ram_read_en_i = 1'b0;
  logic        ram_write_en_i = 1'b0;
  logic [31:0] pc_next_i = 32'h4;
  state_t      state_o;
  logic        stall_o;
  logic        active_o;
  logic [31:0] cycle_count_o;
  logic [31:0] instr_count_o;
  logic [31:0] stall_count_o;

  logic       sat_clear = 1'b1;
  logic       sat_inc = 1'b0;
  logic [3:0] sat_count;

  int checks = 0;
  int failures = 0;

  // Model: instruction phase 0..2 and a halted flag; counters as wide ints.
  int     m_phase;
  bit     m_halted;
  longint m_cyc, m_ins, m_stl;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .waitrequest_i  (waitrequest_i),
    .ram_read_en_i  (ram_read_en_i),
    .ram_write_en_i (ram_write_en_i),
    .pc_next_i      (pc_next_i),
    .state_o        (state_o),
    .stall_o        (stall_o),
    .active_o       (active_o),
    .cycle_count_o  (cycle_count_o),
    .instr_count_o  (instr_count_o),
    .stall_count_o  (stall_count_o)
  );

  sat_counter #(.WIDTH(4)) u_sat (
    .clk     (clk),
    .clear   (sat_clear),
    .inc_i   (sat_inc),
    .count_o (sat_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat32(input longint v);
    return (v > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v;
  endfunction

  // One clock: drive inputs, check the combinational stall, clock, then
  // advance the model and compare registered outputs.
  task automatic step(input bit rst, input bit rd, input bit wr, input bit wt,
                      input logic [31:0] pc);
    bit exp_stall;
    reset          = rst;
    ram_read_en_i  = rd;
    ram_write_en_i = wr;
    waitrequest_i  = wt;
    pc_next_i      = pc;
    #2;
    exp_stall = (rd | wr) & wt & !m_halted;
    if (!rst) check_val("stall_o", {31'b0, stall_o}, {31'b0, exp_stall});
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_halted = 0; m_cyc = 0; m_ins = 0; m_stl = 0;
    end else if (!m_halted) begin
      m_cyc = sat32(m_cyc + 1);
      if (exp_stall) begin
        m_stl = sat32(m_stl + 1);
      end else if (m_phase == 2) begin
        m_ins = sat32(m_ins + 1);
        if (pc == 32'h0) m_halted = 1;
        else m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
    end
    #1;
    check_val("state", 32'(state_o), m_halted ? 32'd3 : 32'(m_phase));
    check_val("active", {31'b0, active_o}, {31'b0, !m_halted});
    check_val("cycle_cnt", cycle_count_o, m_cyc[31:0]);
    check_val("instr_cnt", instr_count_o, m_ins[31:0]);
    check_val("stall_cnt", stall_count_o, m_stl[31:0]);
    $display("cyc rst=%0b rd=%0b wr=%0b wt=%0b pc=%08h -> st=%0d stall=%0b act=%0b cc=%0d ic=%0d sc=%0d",
             rst, rd, wr, wt, pc, state_o, stall_o, active_o,
             cycle_count_o, instr_count_o, stall_count_o);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_phase = 0; m_halted = 0; m_cyc = 0; m_ins = 0; m_stl = 0;

    // Reset state and two unstalled instructions.
    step(1, 0, 0, 0, 32'h4);
    check_val("rst_state", 32'(state_o), 32'd0);
    check_val("rst_active", {31'b0, active_o}, 32'd1);
    check_val("rst_cycle", cycle_count_o, 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 32'h4);
    check_val("two_instr_ic", instr_count_o, 32'd2);
    check_val("two_instr_cc", cycle_count_o, 32'd6);

    // FETCH read stalled for three cycles.
    step(1, 0, 0, 0, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 32'h4);
      check_val("fetch_hold", 32'(state_o), 32'd0);
    end
    step(0, 1, 0, 0, 32'h4);
    check_val("fetch_release", 32'(state_o), 32'd1);
    check_val("fetch_stalls", stall_count_o, 32'd3);

    // waitrequest without a memory request in EXEC1.
    step(0, 0, 0, 1, 32'h4);
    check_val("wait_no_req", 32'(state_o), 32'd2);

    // Halt on zero next-PC, then frozen for ten cycles under noise.
    step(1, 0, 0, 0, 32'h4);
    step(0, 0, 0, 0, 32'h4);
    step(0, 0, 0, 0, 32'h4);
    step(0, 0, 0, 0, 32'h0);
    check_val("halt_active", {31'b0, active_o}, 32'd0);
    check_val("halt_ic", instr_count_o, 32'd1);
    check_val("halt_cc", cycle_count_o, 32'd3);
    for (int i = 0; i < 10; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    check_val("frozen_cc", cycle_count_o, 32'd3);
    check_val("frozen_ic", instr_count_o, 32'd1);

    // Stall in EXEC2 competing with a halt PC, then reset mid-stall.
    step(1, 0, 0, 0, 32'h4);
    step(0, 0, 0, 0, 32'h4);
    step(0, 0, 0, 0, 32'h4);
    step(0, 0, 1, 1, 32'h0);
    check_val("stall_beats_halt", 32'(state_o), 32'd2);
    step(0, 0, 1, 1, 32'h0);
    step(1, 0, 1, 1, 32'h0);
    check_val("rst_mid_state", 32'(state_o), 32'd0);
    check_val("rst_mid_stall", stall_count_o, 32'd0);
    check_val("rst_mid_active", {31'b0, active_o}, 32'd1);

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      step(rst, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
    end

    // Saturation on a narrow counter instance.
    begin
      int n;
      sat_clear = 1'b1; sat_inc = 1'b1;
      @(posedge clk); #1;
      check_val("sat_clear_prio", {28'b0, sat_count}, 32'd0);
      sat_clear = 1'b0;
      n = 0;
      for (int i = 0; i < 18; i++) begin
        @(posedge clk); #1;
        n = (n < 15) ? n + 1 : 15;
        check_val("sat_count", {28'b0, sat_count}, 32'(n));
        $display("sat inc=1 -> count=%0d", sat_count);
      end
      sat_inc = 1'b0;
      @(posedge clk); #1;
      check_val("sat_hold", {28'b0, sat_count}, 32'd15);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
